// File: rtl/cos_job_scheduler.sv
// cos_job_scheduler: shares one cosine accelerator between two requesters.
// Round-robin arbitration, start/done sequencing of the core with a per-job
// timeout, and a single tagged valid/ready response channel.
module cos_job_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [15:0]     r0_xin,
  input  logic [7:0]      r0_yin,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [15:0]     r1_xin,
  input  logic [7:0]      r1_yin,
  output logic            eng_start,
  output logic [15:0]     eng_xin,
  output logic [7:0]      eng_yin,
  input  logic            eng_done,
  input  logic [15:0]     eng_cosx,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [15:0]     rsp_cosx,
  output logic            rsp_err,
  output logic            busy,
  output logic [CNTW-1:0] err_cnt
);

  localparam int            TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            eng_start_q, eng_start_d;
  logic [15:0]     xin_q, xin_d;
  logic [7:0]      yin_q, yin_d;
  logic            id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     cosx_q, cosx_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            grant;
  logic            accept;

  // Round-robin grant: a lone requester wins, on a tie the one not served last wins.
  always_comb begin
    grant    = r1_valid && !(r0_valid && last_grant_q);
    r0_ready = (state_q == S_IDLE) && !grant && r0_valid;
    r1_ready = (state_q == S_IDLE) && grant && r1_valid;
    accept   = r0_ready || r1_ready;
  end

  // Next-state and datapath capture for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    eng_start_d  = 1'b0;
    xin_d        = xin_q;
    yin_d        = yin_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    cosx_d       = cosx_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;
    timer_d      = timer_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          xin_d        = grant ? r1_xin : r0_xin;
          yin_d        = grant ? r1_yin : r0_yin;
          id_d         = grant;
          last_grant_d = grant;
          eng_start_d  = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A completion on the expiry cycle still counts as a good result.
        if (eng_done) begin
          cosx_d      = eng_cosx;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (timer_q == TLAST) begin
          cosx_d      = '0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      eng_start_q  <= 1'b0;
      xin_q        <= '0;
      yin_q        <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cosx_q       <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      eng_start_q  <= eng_start_d;
      xin_q        <= xin_d;
      yin_q        <= yin_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      cosx_q       <= cosx_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign eng_start = eng_start_q;
  assign eng_xin   = xin_q;
  assign eng_yin   = yin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_cosx  = cosx_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cos_job_scheduler.sv
// Scoreboard bench for cos_job_scheduler: stimulus pushes expected grants,
// engine operands and responses; a negedge monitor pops and compares them.
module tb_cos_job_scheduler;

  localparam int TIMEOUT = 64;
  localparam int CNTW    = 8;

  logic            clk;
  logic            rst;
  logic            r0_valid, r0_ready, r1_valid, r1_ready;
  logic [15:0]     r0_xin, r1_xin;
  logic [7:0]      r0_yin, r1_yin;
  logic            eng_start, eng_done;
  logic [15:0]     eng_xin, eng_cosx;
  logic [7:0]      eng_yin;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0]     rsp_cosx;
  logic [CNTW-1:0] err_cnt;

  cos_job_scheduler #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_xin(r0_xin), .r0_yin(r0_yin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_xin(r1_xin), .r1_yin(r1_yin),
    .eng_start(eng_start), .eng_xin(eng_xin), .eng_yin(eng_yin),
    .eng_done(eng_done), .eng_cosx(eng_cosx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cosx(rsp_cosx), .rsp_err(rsp_err), .busy(busy), .err_cnt(err_cnt)
  );

  typedef struct {
    logic        id;
    logic [15:0] cosx;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  y;
  } op_t;

  logic grant_q[$];
  op_t  op_q[$];
  rsp_t rsp_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // engine model controls: mode 0 fixed value, 1 xin^5A5A, 2 never done
  int          eng_mode = 0;
  int          eng_k    = 1;
  logic [15:0] eng_val  = 16'h0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // Engine model: done pulse k cycles after the start cycle.
  initial begin
    int          cnt;
    logic [15:0] cap;
    cnt      = 0;
    cap      = 16'h0;
    eng_done = 1'b0;
    eng_cosx = 16'h0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1;
          eng_cosx = cap;
        end
      end
      if (eng_start && eng_mode != 2) begin
        cnt = eng_k;
        cap = (eng_mode == 1) ? (eng_xin ^ 16'h5A5A) : eng_val;
      end
    end
  end

  // Monitor: grants, engine issue and responses against the queues.
  int   acc_cyc   = 0;
  int   start_cyc = 0;
  int   first_cyc = 0;
  logic prev_rv   = 1'b0;
  always @(negedge clk) begin
    logic g;
    op_t  o;
    rsp_t r;
    if (r0_ready || r1_ready) begin
      check("one_ready", 32'(r0_ready & r1_ready), 32'd0);
      if (grant_q.size() == 0) fail_now("unexpected_grant");
      else begin
        g = grant_q.pop_front();
        check("grant_id", 32'(r1_ready), 32'(g));
      end
      acc_cyc = cyc;
    end
    if (eng_start) begin
      if (op_q.size() == 0) fail_now("unexpected_start");
      else begin
        o = op_q.pop_front();
        check("eng_xin", 32'(eng_xin), 32'(o.x));
        check("eng_yin", 32'(eng_yin), 32'(o.y));
        check("start_lat", 32'(cyc - acc_cyc), 32'd1);
      end
      start_cyc = cyc;
    end
    if (rsp_valid && !prev_rv) first_cyc = cyc;
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) fail_now("unexpected_rsp");
      else begin
        r = rsp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(r.id));
        check("rsp_cosx", 32'(rsp_cosx), 32'(r.cosx));
        check("rsp_err", 32'(rsp_err), 32'(r.err));
        check("rsp_lat", 32'(first_cyc - start_cyc), 32'(r.lat));
      end
    end
    prev_rv = rsp_valid;
  end

  task automatic push_job(input logic id, input logic [15:0] x, input logic [7:0] y,
                          input logic [15:0] cosx, input logic err, input int lat,
                          input logic with_rsp);
    op_t  o;
    rsp_t r;
    o.x = x; o.y = y;
    r.id = id; r.cosx = cosx; r.err = err; r.lat = lat;
    grant_q.push_back(id);
    op_q.push_back(o);
    if (with_rsp) rsp_q.push_back(r);
  endtask

  // Present one job on a single requester and return once it is accepted.
  task automatic run_job(input logic id, input logic [15:0] x, input logic [7:0] y,
                         input logic [15:0] cosx, input logic err, input int lat,
                         input logic with_rsp);
    int  g;
    logic seen;
    push_job(id, x, y, cosx, err, lat, with_rsp);
    @(posedge clk); #1;
    if (id) begin r1_valid = 1'b1; r1_xin = x; r1_yin = y; end
    else    begin r0_valid = 1'b1; r0_xin = x; r0_yin = y; end
    g = 0;
    seen = 1'b0;
    while (!seen && g < 200) begin
      @(negedge clk);
      g++;
      seen = id ? r1_ready : r0_ready;
    end
    if (!seen) fail_now("accept_timeout");
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((rsp_q.size() != 0 || busy) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) fail_now("drain_timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   g;
    logic seen;
    rst = 1'b0;
    r0_valid = 1'b0; r0_xin = 16'h0; r0_yin = 8'h0;
    r1_valid = 1'b0; r1_xin = 16'h0; r1_yin = 8'h0;
    rsp_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_xin", 32'(eng_xin), 32'd0);
    check("rst_eng_yin", 32'(eng_yin), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_cosx", 32'(rsp_cosx), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // contention: both valid for four jobs, expected order 0,1,0,1
    eng_mode = 1; eng_k = 3;
    for (int i = 0; i < 2; i++) begin
      push_job(1'b0, 16'h1111, 8'h11, 16'h4B4B, 1'b0, 4, 1'b1);
      push_job(1'b1, 16'h2222, 8'h22, 16'h7878, 1'b0, 4, 1'b1);
    end
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_xin = 16'h1111; r0_yin = 8'h11;
    r1_valid = 1'b1; r1_xin = 16'h2222; r1_yin = 8'h22;
    n = 0; g = 0;
    while (n < 4 && g < 400) begin
      @(negedge clk);
      g++;
      if (r0_ready || r1_ready) n++;
    end
    if (n < 4) fail_now("contention_accepts");
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_drain();

    // single job, k=5: start one cycle after accept, response 6 after start
    eng_mode = 0; eng_k = 5; eng_val = 16'h0192;
    run_job(1'b0, 16'h0043, 8'h01, 16'h0192, 1'b0, 6, 1'b1);
    wait_drain();

    // timeout: engine silent, response after TIMEOUT wait cycles
    eng_mode = 2;
    run_job(1'b1, 16'h0AAA, 8'h05, 16'h0000, 1'b1, TIMEOUT + 1, 1'b1);
    wait_drain();
    @(negedge clk);
    check("err_cnt_timeout", 32'(err_cnt), 32'd1);

    // done on the expiry cycle: done wins
    eng_mode = 0; eng_k = TIMEOUT; eng_val = 16'h1234;
    run_job(1'b0, 16'h0100, 8'h02, 16'h1234, 1'b0, TIMEOUT + 1, 1'b1);
    wait_drain();
    @(negedge clk);
    check("err_cnt_collision", 32'(err_cnt), 32'd1);

    // backpressure: response held 10 cycles while r1 waits
    eng_mode = 1; eng_k = 2;
    rsp_ready = 1'b0;
    run_job(1'b0, 16'h0300, 8'h03, 16'h595A, 1'b0, 3, 1'b1);
    push_job(1'b1, 16'h0400, 8'h04, 16'h5E5A, 1'b0, 3, 1'b1);
    r1_valid = 1'b1; r1_xin = 16'h0400; r1_yin = 8'h04;
    g = 0;
    while (!rsp_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!rsp_valid) fail_now("bp_rsp_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(rsp_id), 32'd0);
      check("bp_rsp_cosx", 32'(rsp_cosx), 32'h595A);
      check("bp_rsp_err", 32'(rsp_err), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_no_accept", 32'(r1_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_next", 32'(busy), 32'd0);
    check("bp_accept_next", 32'(r1_ready), 32'd1);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    wait_drain();

    // asynchronous reset in WAIT, stale done afterwards
    eng_mode = 0; eng_k = 20; eng_val = 16'h7777;
    run_job(1'b0, 16'h0600, 8'h06, 16'h7777, 1'b0, 21, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_eng_start", 32'(eng_start), 32'd0);
    check("arst_eng_xin", 32'(eng_xin), 32'd0);
    check("arst_eng_yin", 32'(eng_yin), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("stale_done_busy", 32'(busy), 32'd0);

    // tie after reset goes to requester 0
    eng_mode = 1; eng_k = 3;
    push_job(1'b0, 16'h0500, 8'h05, 16'h5F5A, 1'b0, 4, 1'b1);
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_xin = 16'h0500; r0_yin = 8'h05;
    r1_valid = 1'b1; r1_xin = 16'h0700; r1_yin = 8'h07;
    g = 0; seen = 1'b0;
    while (!seen && g < 50) begin
      @(negedge clk);
      g++;
      seen = r0_ready || r1_ready;
    end
    if (!seen) fail_now("tie_accept_timeout");
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_drain();

    repeat (3) @(negedge clk);
    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("op_q_empty", 32'(op_q.size()), 32'd0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
